prog_counter: RTL and testbench

PROG_COUNTER -- requirements
Module: prog_counter

---
 rtl/prog_counter_pkg.sv | 18 +
 rtl/prog_counter.sv | 88 ++++++++
 tb/tb_prog_counter.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/prog_counter_pkg.sv
// Shared types for the programmable counter: counting modes and control FSM states.
package prog_counter_pkg;

  // Behaviour at terminal count. The reserved encoding behaves as WRAP.
  typedef enum logic [1:0] {
    MODE_WRAP    = 2'b00,
    MODE_SAT     = 2'b01,
    MODE_ONESHOT = 2'b10,
    MODE_RSVD    = 2'b11
  } mode_e;

  // Control FSM: HALT is entered only by a ONESHOT terminal step.
  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_e;

endpackage

// File: rtl/prog_counter.sv
// Programmable up/down counter with WRAP / SAT / ONESHOT terminal behaviour,
// a registered terminal-count pulse and a sticky overflow flag.
module prog_counter
  import prog_counter_pkg::*;
#(
  parameter int unsigned        WIDTH     = 8,
  parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dir,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] max_val,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf,
  output logic             halted
);

  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  state_e           state_q, state_d;
  logic             term;
  mode_e            mode_s;

  assign mode_s = mode_e'(mode);

  // Next-state: clr > load > enabled step > hold; terminal handling per mode.
  always_comb begin
    count_d = count_q;
    state_d = state_q;
    tc_d    = 1'b0;
    ovf_d   = ovf_q & ~ovf_clr;
    // Up-count treats anything at or above max_val as terminal so that
    // out-of-range loads still wrap/saturate rather than run to 2^WIDTH.
    term    = dir ? (count_q == '0) : (count_q >= max_val);

    if (clr) begin
      count_d = '0;
      state_d = ST_RUN;
    end else if (load) begin
      count_d = load_val;
      state_d = ST_RUN;
    end else if (en && (state_q == ST_RUN)) begin
      if (!term) begin
        count_d = dir ? (count_q - WIDTH'(1)) : (count_q + WIDTH'(1));
      end else begin
        tc_d = 1'b1;
        case (mode_s)
          MODE_SAT:     count_d = count_q;
          MODE_ONESHOT: state_d = ST_HALT;
          default: begin
            // WRAP and reserved: wrap and flag; set wins over ovf_clr.
            count_d = dir ? max_val : '0;
            ovf_d   = 1'b1;
          end
        endcase
      end
    end
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= RESET_VAL;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
      state_q <= ST_RUN;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
      state_q <= state_d;
    end
  end

  assign count  = count_q;
  assign tc     = tc_q;
  assign ovf    = ovf_q;
  assign halted = (state_q == ST_HALT);

endmodule

// File: tb/tb_prog_counter.sv
// Directed + randomized check of prog_counter (WIDTH=4, RESET_VAL=0) against
// a behavioural model built from the counting rules.
module tb_prog_counter;

  logic       clk = 1'b0;
  logic       rst, en, clr, load, dir, ovf_clr;
  logic [3:0] load_val, max_val, count;
  logic [1:0] mode;
  logic       tc, ovf, halted;

  int total = 0;
  int bad   = 0;
  int tc_seen;

  // behavioural model state
  int m_count;
  bit m_halt, m_ovf, m_tc;

  prog_counter #(.WIDTH(4), .RESET_VAL(4'd0)) dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .load(load), .load_val(load_val),
    .dir(dir), .mode(mode), .max_val(max_val), .ovf_clr(ovf_clr),
    .count(count), .tc(tc), .ovf(ovf), .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Model of one rising edge, computed from the current inputs.
  task automatic model_edge();
    bit at_term;
    at_term = dir ? (m_count == 0) : (m_count >= int'(max_val));
    m_tc  = 1'b0;
    m_ovf = m_ovf && !ovf_clr;
    if (clr) begin
      m_count = 0; m_halt = 1'b0;
    end else if (load) begin
      m_count = int'(load_val); m_halt = 1'b0;
    end else if (en && !m_halt) begin
      if (at_term) begin
        m_tc = 1'b1;
        if (mode == 2'd2) m_halt = 1'b1;
        else if (mode != 2'd1) begin
          m_count = dir ? int'(max_val) : 0;
          m_ovf   = 1'b1;
        end
      end else begin
        m_count = (m_count + (dir ? 15 : 1)) % 16;
      end
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".count"},  int'(count),  m_count);
    chk({tag, ".tc"},     int'(tc),     int'(m_tc));
    chk({tag, ".ovf"},    int'(ovf),    int'(m_ovf));
    chk({tag, ".halted"}, int'(halted), int'(m_halt));
  endtask

  // One clock: model the edge, wait for it, sample 1 time unit later.
  task automatic cyc(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    chk_model(tag);
    if (tc) tc_seen++;
  endtask

  task automatic model_reset();
    m_count = 0; m_halt = 1'b0; m_ovf = 1'b0; m_tc = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 0; clr = 0; load = 0; dir = 0; ovf_clr = 0;
    load_val = 0; max_val = 4'd9; mode = 2'd0;
    model_reset();
    #12;
    chk("reset.count", int'(count), 0);
    chk("reset.tc", int'(tc), 0);
    chk("reset.ovf", int'(ovf), 0);
    chk("reset.halted", int'(halted), 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // WRAP up to 9: 0..9,0,1
    en = 1; tc_seen = 0;
    for (int i = 0; i < 11; i++) begin
      cyc("wrap_up");
      chk("wrap_up.seq", int'(count), (i + 1) % 10);
    end
    chk("wrap_up.tc_pulses", tc_seen, 1);
    chk("wrap_up.ovf", int'(ovf), 1);

    // WRAP down from 2: 2,1,0,9,8
    en = 0; ovf_clr = 1;
    cyc("ovfclr");
    chk("ovfclr.ovf", int'(ovf), 0);
    ovf_clr = 0; dir = 1; load = 1; load_val = 4'd2;
    cyc("wrap_dn_load");
    chk("wrap_dn_load.count", int'(count), 2);
    load = 0; en = 1; tc_seen = 0;
    for (int i = 0; i < 4; i++) begin
      cyc("wrap_dn");
      chk("wrap_dn.seq", int'(count), (i == 0) ? 1 : (i == 1) ? 0 : (i == 2) ? 9 : 8);
    end
    chk("wrap_dn.tc_pulses", tc_seen, 1);
    chk("wrap_dn.ovf", int'(ovf), 1);
    en = 0; ovf_clr = 1;
    cyc("wrap_dn_ovfclr");
    chk("wrap_dn_ovfclr.ovf", int'(ovf), 0);
    ovf_clr = 0;

    // SAT up to 5
    dir = 0; mode = 2'd1; max_val = 4'd5; clr = 1;
    cyc("sat_clr");
    clr = 0; en = 1;
    for (int i = 1; i <= 8; i++) begin
      cyc("sat");
      chk("sat.seq", int'(count), (i < 5) ? i : 5);
      chk("sat.tc", int'(tc), (i >= 6) ? 1 : 0);
      chk("sat.ovf", int'(ovf), 0);
    end

    // ONESHOT up to 3, halt, reload, wrap out of range load
    mode = 2'd2; max_val = 4'd3; clr = 1; en = 0;
    cyc("one_clr");
    clr = 0; en = 1;
    for (int i = 0; i < 4; i++) cyc("one_run");
    chk("one.halted", int'(halted), 1);
    chk("one.count", int'(count), 3);
    for (int i = 0; i < 4; i++) begin
      cyc("one_halt");
      chk("one_halt.count", int'(count), 3);
      chk("one_halt.tc", int'(tc), 0);
    end
    en = 0; load = 1; load_val = 4'd7;
    cyc("one_load");
    chk("one_load.halted", int'(halted), 0);
    chk("one_load.count", int'(count), 7);
    load = 0; mode = 2'd0; en = 1;
    cyc("one_wrap");
    chk("one_wrap.count", int'(count), 0);

    // clr/load/en together, then async reset mid-count
    clr = 1; load = 1; load_val = 4'd6; en = 1; max_val = 4'd9;
    cyc("prio");
    chk("prio.count", int'(count), 0);
    chk("prio.tc", int'(tc), 0);
    clr = 0; load = 0;
    for (int i = 0; i < 4; i++) cyc("pre_rst");
    chk("pre_rst.count", int'(count), 4);
    #1 rst = 1'b1;
    #1;
    model_reset();
    chk_model("async_rst");
    #1 rst = 1'b0;
    cyc("post_rst");
    chk("post_rst.count", int'(count), 1);

    // Randomized phase, including reserved mode and ovf_clr collisions
    for (int i = 0; i < 400; i++) begin
      en       = ($urandom_range(0, 9) != 0);
      clr      = ($urandom_range(0, 29) == 0);
      load     = ($urandom_range(0, 14) == 0);
      load_val = 4'($urandom_range(0, 15));
      dir      = ($urandom_range(0, 3) == 0) ? ~dir : dir;
      mode     = ($urandom_range(0, 19) == 0) ? 2'($urandom_range(0, 3)) : mode;
      max_val  = ($urandom_range(0, 24) == 0) ? 4'($urandom_range(1, 15)) : max_val;
      ovf_clr  = ($urandom_range(0, 4) == 0);
      cyc("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
